// File: rtl/core_irq_pkg.sv
// Shared constants for the Core interrupt controller: register word
// addresses, data width and the maximum number of request sources.
package core_irq_pkg;

    localparam int DATA_W          = 16;
    localparam int IRQ_MAX_SOURCES = 16;

    localparam logic [2:0] IRQ_ADDR_PENDING = 3'd0;
    localparam logic [2:0] IRQ_ADDR_MASK    = 3'd1;
    localparam logic [2:0] IRQ_ADDR_EDGE    = 3'd2;
    localparam logic [2:0] IRQ_ADDR_RAW     = 3'd3;
    localparam logic [2:0] IRQ_ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] IRQ_ADDR_FORCE   = 3'd5;

endpackage

// File: rtl/core_irq_ctrl_if.sv
// Avalon-MM slave bus of the interrupt controller (3-bit word address,
// 16-bit data, read latency 1).
interface core_irq_ctrl_if;
    import core_irq_pkg::*;

    logic              chipselect;
    logic [2:0]        address;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, address, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/core_irq_sync.sv
// Per-bit synchronizer chain (STAGES deep, 0 = pass-through) followed by
// one history flop used to detect rising edges of the synchronized value.
module core_irq_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] s,
    output logic [W-1:0] rise
);

    logic [W-1:0] sd_q;
    logic [W-1:0] sd_d;

    if (STAGES == 0) begin : g_direct
        assign s = d;
    end else begin : g_chain
        logic [W-1:0] chain_q [STAGES];
        logic [W-1:0] chain_d [STAGES];

        always_comb begin
            chain_d[0] = d;
            for (int k = 1; k < STAGES; k++) begin
                chain_d[k] = chain_q[k-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < STAGES; k++) begin
                    chain_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < STAGES; k++) begin
                    chain_q[k] <= chain_d[k];
                end
            end
        end

        assign s = chain_q[STAGES-1];
    end

    assign sd_d = s;
    assign rise = s & ~sd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sd_q <= '0;
        else       sd_q <= sd_d;
    end

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt controller: latches edge/level requests, masks them and drives
// a registered irq_out. Optional VECTOR encoder: CORE_IRQ_CTRL_PRIORITY_EN.
module core_irq_ctrl
    import core_irq_pkg::*;
#(
    parameter int                NUM_IRQ     = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] EDGE_RESET  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    core_irq_ctrl_if.slave     bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    // Registers are kept DATA_W wide; unimplemented bits are held at 0.
    localparam logic [DATA_W:0]   ONE  = 1;
    localparam logic [DATA_W-1:0] IMPL = DATA_W'((ONE << NUM_IRQ) - ONE);

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [DATA_W-1:0]  s16;
    logic [DATA_W-1:0]  rise16;

    logic [DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic              wr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] w1c;
    logic [DATA_W-1:0] fset;
    logic [DATA_W-1:0] pending;
    logic [DATA_W-1:0] vec;

    core_irq_sync #(
        .W      (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .s     (s),
        .rise  (rise)
    );

    assign s16    = DATA_W'(s);
    assign rise16 = DATA_W'(rise);
    assign wr     = bus.chipselect & ~bus.write_n;
    assign wd     = bus.writedata & IMPL;

    always_comb begin
        w1c    = '0;
        fset   = '0;
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr) begin
            case (bus.address)
                IRQ_ADDR_PENDING: w1c    = wd;
                IRQ_ADDR_MASK:    mask_d = wd;
                IRQ_ADDR_EDGE:    edge_d = wd;
                IRQ_ADDR_FORCE:   fset   = wd;
                default: ;
            endcase
        end
    end

    // Set terms are ORed after the clear so a same-cycle event survives W1C.
    always_comb begin
        pend_d  = fset | (edge_q & rise16) | (pend_q & ~w1c);
        pending = pend_q | (~edge_q & s16);
        irq_d   = |(pending & mask_q);
    end

`ifdef CORE_IRQ_CTRL_PRIORITY_EN
    logic [DATA_W-1:0] act;

    always_comb begin
        act = pending & mask_q;
        vec = '0;
        for (int i = IRQ_MAX_SOURCES - 1; i >= 0; i--) begin
            if (act[i]) vec = {1'b1, 11'b0, 4'(i)};
        end
    end
`else
    assign vec = '0;
`endif

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            IRQ_ADDR_PENDING: readdata_d = pending;
            IRQ_ADDR_MASK:    readdata_d = mask_q;
            IRQ_ADDR_EDGE:    readdata_d = edge_q;
            IRQ_ADDR_RAW:     readdata_d = s16;
            IRQ_ADDR_VECTOR:  readdata_d = vec;
            default:          readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            mask_q     <= '0;
            edge_q     <= EDGE_RESET & IMPL;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_q;

endmodule
